// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter. It accepts bytes from the bus
// side at full clock rate. A small drain FSM hands the bytes to the
// transmitter one at a time through its write/data/busy handshake.
module uart_tx_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [7:0]   wr_data,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count,
  output logic         overflow,
  input  logic         clear_overflow,
  output logic         tx_write,
  output logic [7:0]   tx_data,
  input  logic         tx_busy
);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count_nxt;
  logic            push, pop;

  // full is the registered pre-edge value, so a push while full is dropped
  // even if the drain pops in the same cycle.
  assign push      = wr_en && !full;
  assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);

  // Drain FSM next state. A byte is issued only when the transmitter is idle.
  // This also covers a reset that lands mid-transfer, while the transmitter is
  // still busy.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop       = 1'b1;
          state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: if (tx_busy)  state_nxt = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Byte storage. It is not reset: stale entries are unreachable once the
  // pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and status flags, all registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
      // When both happen in the same cycle, the set beats the clear.
      if (wr_en && full)       overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  // Transmitter interface. tx_write is a one-cycle pulse on each issue.
  // tx_data holds the issued byte until the next issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_write <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_write <= pop;
      if (pop) tx_data <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo. The stimulus pushes the expected bytes
// into a queue. A monitor pops from that queue and compares on every tx_write
// pulse. A simple transmitter model raises busy one cycle after it captures a
// byte and holds busy for tx_len cycles.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset, wr_en, clear_overflow, tx_busy;
  logic [7:0] wr_data;
  logic       full, empty, overflow, tx_write;
  logic [4:0] count;
  logic [7:0] tx_data;

  int         vectors = 0, miscompares = 0, n_pulses = 0;
  int         busy_cnt = 0, tx_len = 10;
  logic       force_busy = 1'b0, prev_write = 1'b0;
  logic [7:0] exp_q [$];

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .clear_overflow(clear_overflow), .tx_write(tx_write),
    .tx_data(tx_data), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  // Transmitter model. It has no reset, so it keeps running across a DUT
  // reset. It captures on tx_write and is busy from the next cycle on.
  always @(posedge clk) begin
    if (tx_write && busy_cnt == 0) busy_cnt <= tx_len;
    else if (busy_cnt != 0)        busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = force_busy || (busy_cnt != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: sample away from the active edge. Compare each issued byte with
  // the head of the scoreboard, and check the handshake rules.
  always @(negedge clk) begin
    if (tx_write) begin
      n_pulses++;
      check("write_while_busy", tx_busy, 1'b0);
      check("write_two_cycles", prev_write, 1'b0);
      if (exp_q.size() == 0) check("unexpected_tx_write", 1'b1, 1'b0);
      else check("tx_data_order", tx_data, exp_q.pop_front());
    end
    prev_write = tx_write;
  end

  // Caller sits at a negedge. Each call occupies exactly one clock, so
  // consecutive calls push back-to-back.
  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (!(empty && !tx_busy && !tx_write && exp_q.size() == 0) && n < 3000) begin
      @(negedge clk); n++;
    end
    check(name, {31'd0, (exp_q.size() == 0 && empty)}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    int n = 0;
    while (tx_busy !== lvl && n < 500) begin
      @(negedge clk); n++;
    end
    check(name, tx_busy, lvl);
  endtask

  initial begin
    int p0;
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clear_overflow = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_count", count, 5'd0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_tx_write", tx_write, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);

    // 1: single byte, latency of two edges, FIFO is empty again once issued
    tx_len = 4;
    exp_q.push_back(8'h55);
    push(8'h55);
    check("t1_count_after_push", count, 5'd1);
    check("t1_no_write_yet", tx_write, 1'b0);
    @(negedge clk);
    check("t1_tx_write", tx_write, 1'b1);
    check("t1_tx_data", tx_data, 8'h55);
    check("t1_count_zero", count, 5'd0);
    check("t1_empty", empty, 1'b1);
    wait_drain("t1_drain");

    // 2: "Hi\n" back-to-back, exactly three pulses
    tx_len = 10;
    p0 = n_pulses;
    exp_q.push_back(8'h48); exp_q.push_back(8'h69); exp_q.push_back(8'h0A);
    push(8'h48); push(8'h69); push(8'h0A);
    wait_drain("t2_drain");
    check("t2_pulses", n_pulses - p0, 3);

    // 3: overflow with the transmitter held busy
    force_busy = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (i < DEPTH) exp_q.push_back(8'hA0 + 8'(i));
      push(8'hA0 + 8'(i));
    end
    check("t3_count_full", count, 5'd16);
    check("t3_full", full, 1'b1);
    check("t3_overflow", overflow, 1'b1);
    // A push while full and a clear in the same cycle: the set wins.
    wr_en = 1'b1; wr_data = 8'hEE; clear_overflow = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    check("t3_set_beats_clear", overflow, 1'b1);
    @(negedge clk);
    clear_overflow = 1'b0;
    check("t3_overflow_cleared", overflow, 1'b0);
    check("t3_count_held", count, 5'd16);
    force_busy = 1'b0;
    tx_len = 3;
    wait_drain("t3_drain");

    // 4: 3*DEPTH incrementing bytes while draining, across pointer wrap
    for (int i = 0; i < 3 * DEPTH; i++) begin
      int n = 0;
      while (full && n < 1000) begin @(negedge clk); n++; end
      exp_q.push_back(8'(i));
      push(8'(i));
    end
    wait_drain("t4_drain");
    check("t4_no_overflow", overflow, 1'b0);

    // 6: a push and a drain pop in the same cycle at count=5
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'hC0 + 8'(i));
      push(8'hC0 + 8'(i));
    end
    check("t6_count5", count, 5'd5);
    force_busy = 1'b0;
    exp_q.push_back(8'hC5);
    push(8'hC5);
    check("t6_count_stays5", count, 5'd5);
    check("t6_popped", tx_write, 1'b1);
    wait_drain("t6_drain");

    // 5: reset while the transmitter is busy and the FIFO holds 4 bytes
    tx_len = 20;
    exp_q.push_back(8'h11);
    push(8'h11);
    wait_busy(1'b1, "t5_tx_busy_rise");
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h21 + 8'(i));
      push(8'h21 + 8'(i));
    end
    check("t5_count4", count, 5'd4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    check("t5_rst_count", count, 5'd0);
    check("t5_rst_empty", empty, 1'b1);
    p0 = n_pulses;
    wait_busy(1'b0, "t5_tx_busy_fall");
    repeat (5) @(negedge clk);
    check("t5_no_write_after_reset", n_pulses - p0, 0);
    exp_q.push_back(8'h77);
    push(8'h77);
    wait_drain("t5_drain");
    check("t5_one_write", n_pulses - p0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
